sram1rw_fifo_ctrl: RTL and testbench

//  Valid/ready FIFO controller that drives one single-port SRAM1RW256x46 macro
//  as its storage, so the macro can serve as a 256-deep, 46-bit stream buffer.
//  It sits directly upstream of the macro: it generates A/CSB/WEB/OEB/I,

---
 rtl/sram1rw_fifo_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sram1rw_fifo_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram1rw_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sram1rw_fifo_ctrl
//   Valid/ready FIFO controller around one single-port SRAM1RW256x46 macro.
//   The macro holds up to DEPTH words. A 2-entry output buffer hides the
//   macro's one-cycle registered read. One SRAM operation runs per cycle, and
//   reads and writes share the port under one-bit round-robin arbitration.
//
//   Optional feature: define SRAM1RW_FIFO_HWM_EN to add the hwm output. hwm is
//   the highest value level has reached since reset.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   in_valid/in_ready     producer handshake; in_ready is combinational
//   in_data               producer word
//   out_valid/out_ready   consumer handshake; out_data is the buffer head
//   level                 words held in the SRAM (0..DEPTH); buffer excluded
//   sram_A/CSB/WEB/OEB/I  macro controls (active-low strobes), write data
//   sram_O                macro read data, valid the cycle after a read edge
//   hwm                   (SRAM1RW_FIFO_HWM_EN only) level high-water mark
// ---------------------------------------------------------------------------
module sram1rw_fifo_ctrl #(
    parameter int unsigned DATA_W = 46,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W-1:0] sram_A,
    output logic              sram_CSB,
    output logic              sram_WEB,
    output logic              sram_OEB,
    output logic [DATA_W-1:0] sram_I,
    input  logic [DATA_W-1:0] sram_O
`ifdef SRAM1RW_FIFO_HWM_EN
    ,
    output logic [ADDR_W:0]   hwm
`endif
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned LVL_W   = ADDR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    typedef enum logic {
        PRIO_RD = 1'b0,
        PRIO_WR = 1'b1
    } prio_e;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_nxt;
    logic [1:0]        buf_cnt;
    logic [1:0]        buf_cnt_nxt;
    logic              buf_head;
    logic              buf_tail;
    logic [DATA_W-1:0] buf_mem [2];
    logic              rd_inflight;
    prio_e             prio;
    logic [ADDR_W-1:0] last_a;
    logic [DATA_W-1:0] last_i;

    logic not_full;
    logic want_rd;
    logic want_wr;
    logic wr_gnt;
    logic rd_gnt;
    logic pop;

    // Request/grant decode; everything is blocked while reset is high.
    always_comb begin
        not_full = (level_q < DEPTH_L);
        want_rd  = (level_q != '0) &&
                   ((3'(buf_cnt) + 3'(rd_inflight)) < 3'd2);
        want_wr  = in_valid && not_full;
        // in_ready deliberately excludes in_valid so it has no input path.
        in_ready = !reset && not_full && !(want_rd && (prio == PRIO_RD));
        wr_gnt   = in_valid && in_ready;
        rd_gnt   = !reset && want_rd && !wr_gnt;
        pop      = out_valid && out_ready;
    end

    // SRAM strobes; address and write data hold their last value when idle.
    always_comb begin
        sram_CSB = !(wr_gnt || rd_gnt);
        sram_WEB = !wr_gnt;
        sram_OEB = !rd_gnt;
        sram_A   = last_a;
        sram_I   = last_i;
        if (wr_gnt) begin
            sram_A = wr_ptr;
            sram_I = in_data;
        end else if (rd_gnt) begin
            sram_A = rd_ptr;
        end
    end

    // Next level and buffer occupancy.
    always_comb begin
        level_nxt = level_q;
        if (wr_gnt) begin
            level_nxt = level_q + LVL_W'(1);
        end else if (rd_gnt) begin
            level_nxt = level_q - LVL_W'(1);
        end
        // A read issued last cycle lands in the buffer at this edge.
        buf_cnt_nxt = 2'(buf_cnt + 2'(rd_inflight) - 2'(pop));
        buf_tail    = buf_head ^ buf_cnt[0];
    end

    // Control state.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            buf_cnt     <= '0;
            buf_head    <= 1'b0;
            rd_inflight <= 1'b0;
            prio        <= PRIO_RD;
            last_a      <= '0;
            last_i      <= '0;
        end else begin
            if (wr_gnt) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                last_a <= wr_ptr;
                last_i <= in_data;
            end
            if (rd_gnt) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                last_a <= rd_ptr;
            end
            // Contention hands priority to the side that just lost.
            if (want_rd && want_wr) begin
                prio <= (prio == PRIO_RD) ? PRIO_WR : PRIO_RD;
            end
            level_q     <= level_nxt;
            rd_inflight <= rd_gnt;
            buf_cnt     <= buf_cnt_nxt;
            if (pop) begin
                buf_head <= ~buf_head;
            end
        end
    end

    // Output buffer storage; a read in flight at reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && rd_inflight) begin
            buf_mem[buf_tail] <= sram_O;
        end
    end

    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf_mem[buf_head];
    assign level     = level_q;

`ifdef SRAM1RW_FIFO_HWM_EN
    // High-water mark follows level at the edge where level passes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            hwm <= '0;
        end else if (level_nxt > hwm) begin
            hwm <= level_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_sram1rw_fifo_ctrl.sv
module tb_sram1rw_fifo_ctrl;

    localparam int unsigned DATA_W = 46;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W:0]   level;
    logic [ADDR_W-1:0] sram_A;
    logic              sram_CSB;
    logic              sram_WEB;
    logic              sram_OEB;
    logic [DATA_W-1:0] sram_I;
    logic [DATA_W-1:0] sram_O = '0;
`ifdef SRAM1RW_FIFO_HWM_EN
    logic [ADDR_W:0]   hwm;
`endif

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] mem [DEPTH];

    always #5 clock = ~clock;

    sram1rw_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .sram_A    (sram_A),
        .sram_CSB  (sram_CSB),
        .sram_WEB  (sram_WEB),
        .sram_OEB  (sram_OEB),
        .sram_I    (sram_I),
        .sram_O    (sram_O)
`ifdef SRAM1RW_FIFO_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    // Behavioural SRAM1RW macro: registered read, write on the clock edge.
    always @(posedge clock) begin
        if (!sram_CSB) begin
            if (!sram_WEB) mem[sram_A] <= sram_I;
            if (!sram_OEB) sram_O <= mem[sram_A];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push accepted words, pop and compare on each output handshake.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
        end else begin
            check("web_oeb_exclusive", 64'(!sram_WEB && !sram_OEB), 64'(0));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("out_underflow", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("out_data", 64'(out_data), 64'(sb.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                acc_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sb.size() == 0 && !out_valid && level == '0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 64'(done), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] seq;
        logic hs;
        int acc0;
        int prev_g;
        int g;

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_csb", 64'(sram_CSB), 64'(1));
        check("rst_web", 64'(sram_WEB), 64'(1));
        check("rst_oeb", 64'(sram_OEB), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_level", 64'(level), 64'(0));
`ifdef SRAM1RW_FIFO_HWM_EN
        check("rst_hwm", 64'(hwm), 64'(0));
`endif
        step();
        reset = 1'b0;

        // Single word latency
        in_valid = 1'b1;
        in_data = 46'h155_5555_5555;
        out_ready = 1'b1;
        @(negedge clock);
        check("t1_in_ready", 64'(in_ready), 64'(1));
        check("t1_wr_web", 64'(sram_WEB), 64'(0));
        check("t1_wr_addr", 64'(sram_A), 64'(0));
        check("t1_wr_data", 64'(sram_I), 64'h155_5555_5555);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        check("t1_rd_oeb", 64'(sram_OEB), 64'(0));
        check("t1_rd_addr", 64'(sram_A), 64'(0));
        check("t1_level_n1", 64'(level), 64'(1));
        check("t1_ov_n1", 64'(out_valid), 64'(0));
        @(posedge clock);
        @(negedge clock);
        check("t1_ov_n2", 64'(out_valid), 64'(0));
        check("t1_level_n2", 64'(level), 64'(0));
        check("t1_csb_idle", 64'(sram_CSB), 64'(1));
        check("t1_a_hold", 64'(sram_A), 64'(0));
        @(posedge clock);
        @(negedge clock);
        check("t1_ov_n3", 64'(out_valid), 64'(1));
        check("t1_out_data", 64'(out_data), 64'h155_5555_5555);
        check("t1_level_n3", 64'(level), 64'(0));
        step();
        out_ready = 1'b0;

        // Fill to capacity with the consumer stalled
        acc0 = acc_cnt;
        seq = 46'h100;
        in_valid = 1'b1;
        for (int c = 0; c < 700; c++) begin
            in_data = seq;
            @(negedge clock);
            hs = in_valid && in_ready;
            step();
            if (hs) seq = seq + 46'd1;
            if (level == 9'(DEPTH)) break;
        end
        in_data = seq;
        repeat (3) begin
            @(negedge clock);
            check("t2_full_in_ready", 64'(in_ready), 64'(0));
        end
        check("t2_level_full", 64'(level), 64'(256));
        check("t2_accepted", 64'(acc_cnt - acc0), 64'(258));
        check("t2_out_valid", 64'(out_valid), 64'(1));
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain("t2_drain", 1000);

        // Incrementing data across the pointer wrap, random consumer
        seq = '0;
        in_valid = 1'b1;
        for (int c = 0; c < 3000 && seq < 46'd300; c++) begin
            in_data = seq;
            @(negedge clock);
            hs = in_valid && in_ready;
            step();
            if (hs) seq = seq + 46'd1;
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        check("t3_sent", 64'(seq), 64'(300));
        out_ready = 1'b1;
        wait_drain("t3_drain", 1000);

        // Sustained traffic alternates write and read grants
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = 46'(32'hA000 + 32'(c));
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = 46'(32'hB000 + 32'(c));
            step();
        end
        prev_g = 0;
        for (int c = 0; c < 30; c++) begin
            in_data = 46'(32'hC000 + 32'(c));
            @(negedge clock);
            g = !sram_WEB ? 1 : (!sram_OEB ? 2 : 0);
            check("t4_level_pos", 64'(level != '0), 64'(1));
            check("t4_grant_busy", 64'(g != 0), 64'(1));
            if (c > 0) check("t4_alternate", 64'(g != prev_g), 64'(1));
            prev_g = g;
            step();
        end
        in_valid = 1'b0;
        wait_drain("t4_drain", 200);

        // Reset with a read in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 46'h3A5_A5A5_A5A5;
        step();
        in_valid = 1'b0;
        @(negedge clock);
        check("t5_rd_issue", 64'(sram_OEB), 64'(0));
        step();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("t5_out_valid", 64'(out_valid), 64'(0));
        check("t5_level", 64'(level), 64'(0));
        check("t5_csb", 64'(sram_CSB), 64'(1));
        check("t5_in_ready", 64'(in_ready), 64'(0));
        step();
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            check("t5_no_capture", 64'(out_valid), 64'(0));
        end
        step();

`ifdef SRAM1RW_FIFO_HWM_EN
        // High-water mark
        check("t6_hwm_start", 64'(hwm), 64'(0));
        out_ready = 1'b0;
        in_valid = 1'b1;
        seq = 46'h500;
        for (int c = 0; c < 400; c++) begin
            in_data = seq;
            seq = seq + 46'd1;
            step();
            if (level == 9'd100) begin
                in_valid = 1'b0;
                break;
            end
        end
        in_valid = 1'b0;
        check("t6_level_100", 64'(level), 64'(100));
        out_ready = 1'b1;
        wait_drain("t6_drain", 400);
        check("t6_hwm", 64'(hwm), 64'(100));
        reset = 1'b1;
        step();
        step();
        check("t6_hwm_reset", 64'(hwm), 64'(0));
        reset = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
